// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: one outstanding request mapped onto a Wishbone classic cycle.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Pipeline request
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [3:0]  req_sel_i,
  input  logic        req_mis_i,
  input  logic        kill_i,
  // Pipeline response
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic        resp_mis_o,
  output logic        resp_tmo_o,
  // Wishbone master
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {StIdle, StBus, StAbort, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic        tmo_q, tmo_d;

  logic        in_cycle;
  logic        accept_bus;
  logic        tmo_hit;
  logic        bus_done;

  // The bus only sees word addresses; byte offset is already folded into sel.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];

  assign in_cycle   = (state_q == StBus) || (state_q == StAbort);
  assign accept_bus = (state_q == StIdle) && req_valid_i && !kill_i && !req_mis_i;
  assign bus_done   = wb_ack_i || wb_err_i || tmo_hit;

`ifdef LSU_BUS_TIMEOUT_EN
  logic [9:0] cnt_q, cnt_d;

  // cnt_q counts completed wait cycles, so the last permitted cycle sees TIMEOUT_CYCLES-1.
  assign tmo_hit = in_cycle && (cnt_q == 10'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (in_cycle) begin
      cnt_d = cnt_q + 10'd1;
    end else if (accept_bus) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [9:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 10'(TIMEOUT_CYCLES);
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i && !kill_i) begin
          err_d = 1'b0;
          tmo_d = 1'b0;
          mis_d = req_mis_i;
          if (req_mis_i) begin
            state_d = StResp;
          end else begin
            we_d    = req_we_i;
            adr_d   = req_addr_i[31:2];
            dat_d   = req_data_i;
            sel_d   = req_sel_i;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        if (bus_done) begin
          // A flush landing on the completing cycle still discards the response.
          state_d = kill_i ? StIdle : StResp;
          err_d   = wb_err_i || (tmo_hit && !wb_ack_i);
          tmo_d   = tmo_hit && !wb_ack_i && !wb_err_i;
          if (wb_ack_i && !wb_err_i && !we_q && !kill_i) begin
            rdata_d = wb_dat_i;
          end
        end else if (kill_i) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        if (bus_done) begin
          state_d = StIdle;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);

  assign resp_valid_o = (state_q == StResp) && !kill_i;
  assign resp_data_o  = rdata_q;
  assign resp_err_o   = err_q;
  assign resp_mis_o   = mis_q;
  assign resp_tmo_o   = tmo_q;

  // cyc/stb decode straight from state so reset drops them without waiting for a clock.
  assign wb_cyc_o = in_cycle;
  assign wb_stb_o = in_cycle;
  assign wb_we_o  = we_q;
  assign wb_adr_o = {adr_q, 2'b00};
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed cases followed by randomized transactions.
module tb_lsu_bus_ctrl;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned Tmo = 8;
`else
  localparam int unsigned Tmo = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_mis, kill;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_sel;
  logic        req_ready, resp_valid, resp_err, resp_mis, resp_tmo;
  logic [31:0] resp_data;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_sel_i   (req_sel),
    .req_mis_i   (req_mis),
    .kill_i      (kill),
    .resp_valid_o(resp_valid),
    .resp_data_o (resp_data),
    .resp_err_o  (resp_err),
    .resp_mis_o  (resp_mis),
    .resp_tmo_o  (resp_tmo),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_we_o     (wb_we),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Aligned request. mode: 0 ack, 1 err, 2 ack+err. kill_at < 0 means no flush.
  task automatic bus_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input int waits, input int mode,
                         input int kill_at, input logic [31:0] rdata);
    logic killed, exp_err;
    killed  = (kill_at >= 0);
    exp_err = (mode != 0);
    @(negedge clk);
    check("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data; req_sel = sel;
    req_mis = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_data = $urandom;
    req_sel = 4'($urandom);
    for (int k = 0; k <= waits; k++) begin
      check("bus_cyc", {31'd0, wb_cyc}, 32'd1);
      check("bus_stb", {31'd0, wb_stb}, 32'd1);
      check("bus_adr", wb_adr, {addr[31:2], 2'b00});
      check("bus_we", {31'd0, wb_we}, {31'd0, we});
      check("bus_dat", wb_dat_o, data);
      check("bus_sel", {28'd0, wb_sel}, {28'd0, sel});
      check("bus_ready", {31'd0, req_ready}, 32'd0);
      check("bus_noresp", {31'd0, resp_valid}, 32'd0);
      kill = (k == kill_at);
      if (k == waits) begin
        wb_ack = (mode != 1); wb_err = (mode != 0); wb_dat_i = rdata;
      end else begin
        wb_dat_i = $urandom;
      end
      @(negedge clk);
      kill = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
    end
    check("cyc_drop", {31'd0, wb_cyc}, 32'd0);
    if (killed) begin
      check("kill_noresp", {31'd0, resp_valid}, 32'd0);
      check("kill_ready", {31'd0, req_ready}, 32'd1);
    end else begin
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      check("resp_mis", {31'd0, resp_mis}, 32'd0);
      check("resp_tmo", {31'd0, resp_tmo}, 32'd0);
      if (!we && !exp_err) model_rdata = rdata;
      check("resp_data", resp_data, model_rdata);
      @(negedge clk);
      check("resp_pulse", {31'd0, resp_valid}, 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
    end
    check("resp_data_hold", resp_data, model_rdata);
  endtask

  task automatic mis_txn(input logic [31:0] addr, input logic kill_in_resp);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'($urandom); req_addr = addr; req_mis = 1'b1;
    #1 check("mis_nocyc0", {31'd0, wb_cyc}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_mis = 1'b0;
    check("mis_nocyc1", {31'd0, wb_cyc}, 32'd0);
    if (kill_in_resp) begin
      kill = 1'b1;
      #1 check("mis_kill_noresp", {31'd0, resp_valid}, 32'd0);
    end else begin
      check("mis_valid", {31'd0, resp_valid}, 32'd1);
      check("mis_flag", {31'd0, resp_mis}, 32'd1);
      check("mis_err", {31'd0, resp_err}, 32'd0);
      check("mis_data", resp_data, model_rdata);
    end
    @(negedge clk);
    kill = 1'b0;
    check("mis_pulse", {31'd0, resp_valid}, 32'd0);
    check("mis_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drop_txn();
    @(negedge clk);
    req_valid = 1'b1; kill = 1'b1; req_mis = 1'($urandom); req_addr = $urandom;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0; req_mis = 1'b0;
    check("drop_nocyc", {31'd0, wb_cyc}, 32'd0);
    check("drop_noresp", {31'd0, resp_valid}, 32'd0);
    check("drop_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("drop_noresp2", {31'd0, resp_valid}, 32'd0);
  endtask

`ifdef LSU_BUS_TIMEOUT_EN
  task automatic tmo_txn(input int kill_at);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500; req_sel = 4'hf; req_mis = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < int'(Tmo); k++) begin
      check("tmo_cyc", {31'd0, wb_cyc}, 32'd1);
      kill = (k == kill_at);
      @(negedge clk);
      kill = 1'b0;
    end
    check("tmo_cyc_drop", {31'd0, wb_cyc}, 32'd0);
    if (kill_at >= 0) begin
      check("tmo_abort_noresp", {31'd0, resp_valid}, 32'd0);
      check("tmo_abort_ready", {31'd0, req_ready}, 32'd1);
    end else begin
      check("tmo_valid", {31'd0, resp_valid}, 32'd1);
      check("tmo_err", {31'd0, resp_err}, 32'd1);
      check("tmo_flag", {31'd0, resp_tmo}, 32'd1);
      @(negedge clk);
    end
    check("tmo_data", resp_data, model_rdata);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_mis = 1'b0; kill = 1'b0;
    req_addr = '0; req_data = '0; req_sel = '0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
    model_rdata = '0;
    #1;
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_we", {31'd0, wb_we}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_sel", {28'd0, wb_sel}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_flags", {29'd0, resp_err, resp_mis, resp_tmo}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    bus_txn(1'b0, 32'h104, 32'h0, 4'b0001, 0, 0, -1, 32'hDEADBEEF);
    bus_txn(1'b1, 32'h20A, 32'h55AA55AA, 4'b1100, 3, 0, -1, 32'h0BADF00D);
    mis_txn(32'h3, 1'b0);
    bus_txn(1'b0, 32'h300, 32'h0, 4'hf, 2, 0, 0, 32'h12345678);
    bus_txn(1'b0, 32'h400, 32'h0, 4'hf, 1, 2, -1, 32'hCAFEF00D);
    bus_txn(1'b0, 32'h404, 32'h0, 4'hf, 0, 1, -1, 32'hFEEDFACE);
    drop_txn();
    mis_txn(32'h7, 1'b1);
`ifdef LSU_BUS_TIMEOUT_EN
    tmo_txn(-1);
    tmo_txn(2);
`else
    // Without the watchdog a silent slave simply stalls the cycle.
    bus_txn(1'b0, 32'h600, 32'h0, 4'hf, 40, 0, -1, 32'h600D600D);
`endif

    for (int i = 0; i < 40; i++) begin
      int kind, waits, kill_at;
      kind  = int'($urandom_range(0, 99));
      waits = int'($urandom_range(0, 5));
      kill_at = (waits > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, waits - 1))
                                                         : -1;
      if (kind < 70) begin
        bus_txn(1'($urandom), $urandom, $urandom, 4'($urandom), waits,
                int'($urandom_range(0, 2)), kill_at, $urandom);
      end else if (kind < 85) begin
        mis_txn($urandom, 1'($urandom_range(0, 3) == 0));
      end else begin
        drop_txn();
      end
    end

    // Asynchronous reset in the middle of a bus cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h7F0; req_data = 32'h1; req_sel = 4'hf;
    @(negedge clk);
    req_valid = 1'b0;
    check("arst_cyc_pre", {31'd0, wb_cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("arst_stb", {31'd0, wb_stb}, 32'd0);
    check("arst_adr", wb_adr, 32'd0);
    check("arst_resp_data", resp_data, 32'd0);
    check("arst_noresp", {31'd0, resp_valid}, 32'd0);
    model_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_noresp2", {31'd0, resp_valid}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    bus_txn(1'b0, 32'h808, 32'h0, 4'b0011, 1, 0, -1, 32'hA5A5_5A5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
